lcd_msg_scheduler: RTL

- Shares the single LCD character driver (lcdIp) among N_REQ requesters, e.g. brew FSM, error monitor and menu logic.
- Each requester posts a message ID; the block arbitrates round-robin and fetches characters from a message ROM.
- It paces each character into the driver's inputString/send/systemReady handshake with a fixed inter-character gap.
- Sits between the application FSMs and lcdIp; replaces ad-hoc per-design sequencers.

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_msg_rom.sv | 36 +++
 rtl/lcd_msg_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and message content for the LCD message scheduler.
// Message lines are stored left-justified and NUL-padded to one LCD line.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_FETCH = 3'd2,
        ST_GAP   = 3'd3,
        ST_SEND  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_FIN   = 3'd6
    } lcd_state_e;

    localparam logic [7:0] LCD_NUL      = 8'h00;
    localparam int         LCD_LINE_LEN = 16;

    localparam logic [7:0] MSG_READY     = 8'd0;
    localparam logic [7:0] MSG_BREWING   = 8'd1;
    localparam logic [7:0] MSG_NO_WATER  = 8'd2;
    localparam logic [7:0] MSG_DONE      = 8'd3;
    localparam logic [7:0] MSG_ERROR     = 8'd4;
    localparam logic [7:0] MSG_BLANK     = 8'd5;
    localparam logic [7:0] MSG_FULL_LINE = 8'd6;
    localparam logic [7:0] MSG_MENU      = 8'd7;

    // First character sits in the most significant byte.
    function automatic logic [8*LCD_LINE_LEN-1:0] msg_line(input logic [7:0] id);
        case (id)
            MSG_READY:     return {"READY",    {11{LCD_NUL}}};
            MSG_BREWING:   return {"BREWING",  {9{LCD_NUL}}};
            MSG_NO_WATER:  return {"NO WATER", {8{LCD_NUL}}};
            MSG_DONE:      return {"DONE",     {12{LCD_NUL}}};
            MSG_ERROR:     return {"ERROR",    {11{LCD_NUL}}};
            MSG_BLANK:     return {16{LCD_NUL}};
            MSG_FULL_LINE: return "0123456789ABCDEF";
            MSG_MENU:      return {"MENU",     {12{LCD_NUL}}};
            default:       return {16{LCD_NUL}};
        endcase
    endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// Message character ROM, address {msg_id, char_idx}, one cycle read latency.
// MSG_LEN must not exceed one LCD line.
module lcd_msg_rom
    import lcd_pkg::*;
#(
    parameter int MSG_ID_W = 3,
    parameter int MSG_LEN  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MSG_ID_W-1:0]        msg_id,
    input  logic [$clog2(MSG_LEN)-1:0] char_idx,
    output logic [7:0]                 data
);

    logic [8*LCD_LINE_LEN-1:0] line_s;
    logic [7:0]                bytes_s [LCD_LINE_LEN];

    // Split the selected message line into addressable characters.
    always_comb begin
        line_s = msg_line(8'(msg_id));
        for (int i = 0; i < LCD_LINE_LEN; i++) begin
            bytes_s[i] = line_s[8*(LCD_LINE_LEN-1-i) +: 8];
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= LCD_NUL;
        end else begin
            data <= bytes_s[char_idx];
        end
    end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Round-robin scheduler sharing one LCD character driver among N_REQ requesters;
// characters are paced into the driver with a fixed, stall-aware gap.
module lcd_msg_scheduler
    import lcd_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MSG_ID_W = 3,
    parameter int MSG_LEN  = 16,
    parameter int CHAR_GAP = 2500000,
    parameter int HOLD_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*MSG_ID_W-1:0]  req_msg_id,
    input  logic                       systemReady,
    output logic [7:0]                 inputChar,
    output logic                       send,
    output logic [N_REQ-1:0]           pending,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   active_req,
    output logic [N_REQ-1:0]           done
);

    localparam int IDX_W  = $clog2(MSG_LEN + 1);
    localparam int CA_W   = $clog2(MSG_LEN);
    localparam int GAP_W  = ($clog2(CHAR_GAP) > 24) ? $clog2(CHAR_GAP) : 24;
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int RR_W   = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] REQ_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    lcd_state_e           state_r;
    logic [N_REQ-1:0]     pending_r;
    logic [MSG_ID_W-1:0]  id_r [N_REQ];
    logic [MSG_ID_W-1:0]  cur_id_r;
    logic [RR_W-1:0]      rr_r;
    logic [RR_W-1:0]      active_r;
    logic [IDX_W-1:0]     idx_r;
    logic [GAP_W-1:0]     gap_cnt_r;
    logic [HOLD_W-1:0]    hold_cnt_r;
    logic                 fetch_ph_r;
    logic                 busy_r;
    logic                 send_r;
    logic [7:0]           char_r;
    logic [N_REQ-1:0]     done_r;

    logic [7:0]           rom_data_s;
    logic [RR_W-1:0]      grant_idx_s;
    logic                 grant_found_s;
    logic [RR_W-1:0]      cand_s;
    logic                 hit_s;
    logic [N_REQ-1:0]     clr_s;

    function automatic logic [RR_W-1:0] rr_after(input logic [RR_W-1:0] cur);
        if (cur == RR_W'(N_REQ - 1)) begin
            return {RR_W{1'b0}};
        end else begin
            return cur + RR_W'(1'b1);
        end
    endfunction

    lcd_msg_rom #(
        .MSG_ID_W (MSG_ID_W),
        .MSG_LEN  (MSG_LEN)
    ) u_rom (
        .clk      (clk),
        .rst      (rst),
        .msg_id   (cur_id_r),
        .char_idx (idx_r[CA_W-1:0]),
        .data     (rom_data_s)
    );

    // First pending requester at or after the rr pointer, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {RR_W{1'b0}};
        cand_s        = {RR_W{1'b0}};
        hit_s         = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s        = RR_W'((int'(rr_r) + k) % N_REQ);
            hit_s         = pending_r[cand_s] & ~grant_found_s;
            grant_idx_s   = hit_s ? cand_s : grant_idx_s;
            grant_found_s = grant_found_s | hit_s;
        end
        clr_s = (state_r == ST_ARB && grant_found_s) ? (REQ_ONE << grant_idx_s)
                                                      : {N_REQ{1'b0}};
    end

    // A new request always wins over the grant clearing the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {N_REQ{1'b0}};
            for (int i = 0; i < N_REQ; i++) begin
                id_r[i] <= {MSG_ID_W{1'b0}};
            end
        end else begin
            pending_r <= (pending_r & ~clr_s) | req;
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) begin
                    id_r[i] <= req_msg_id[i*MSG_ID_W +: MSG_ID_W];
                end
            end
        end
    end

    // Message sequencer; FETCH spends one cycle waiting on the ROM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_r       <= {RR_W{1'b0}};
            active_r   <= {RR_W{1'b0}};
            cur_id_r   <= {MSG_ID_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
            fetch_ph_r <= 1'b0;
            busy_r     <= 1'b0;
            send_r     <= 1'b0;
            char_r     <= LCD_NUL;
            done_r     <= {N_REQ{1'b0}};
        end else begin
            send_r <= 1'b0;
            done_r <= {N_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (pending_r != {N_REQ{1'b0}}) begin
                        state_r <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (grant_found_s) begin
                        active_r   <= grant_idx_s;
                        cur_id_r   <= id_r[grant_idx_s];
                        busy_r     <= 1'b1;
                        idx_r      <= {IDX_W{1'b0}};
                        fetch_ph_r <= 1'b0;
                        state_r    <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (!fetch_ph_r) begin
                        fetch_ph_r <= 1'b1;
                    end else begin
                        fetch_ph_r <= 1'b0;
                        if (rom_data_s == LCD_NUL || idx_r == IDX_W'(MSG_LEN)) begin
                            done_r  <= REQ_ONE << active_r;
                            busy_r  <= 1'b0;
                            state_r <= ST_FIN;
                        end else begin
                            char_r    <= rom_data_s;
                            gap_cnt_r <= {GAP_W{1'b0}};
                            state_r   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (systemReady) begin
                        if (gap_cnt_r >= GAP_W'(CHAR_GAP - 1)) begin
                            gap_cnt_r <= {GAP_W{1'b0}};
                            send_r    <= 1'b1;
                            state_r   <= ST_SEND;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
                        end
                    end
                end
                ST_SEND: begin
                    idx_r      <= idx_r + IDX_W'(1'b1);
                    hold_cnt_r <= {HOLD_W{1'b0}};
                    state_r    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_W'(HOLD_CYC - 1)) begin
                        hold_cnt_r <= {HOLD_W{1'b0}};
                        state_r    <= ST_FETCH;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
                    end
                end
                ST_FIN: begin
                    rr_r    <= rr_after(active_r);
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign inputChar  = char_r;
    assign send       = send_r;
    assign pending    = pending_r;
    assign busy       = busy_r;
    assign active_req = active_r;
    assign done       = done_r;

endmodule
